// File: rtl/demux1t4_5_buf_if.sv
// Bus bundle for the 1-to-4 buffered demultiplexer: one input stream and four
// independent output streams, each with a valid/ready handshake.
interface demux1t4_5_buf_if #(
  parameter int W = 5
);
  logic [1:0]   s;
  logic [W-1:0] i;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o0;
  logic [W-1:0] o1;
  logic [W-1:0] o2;
  logic [W-1:0] o3;
  logic [3:0]   o_valid;
  logic [3:0]   o_ready;
  logic         busy;
  logic [7:0]   drop_cnt;

  modport master (
    output s, i, in_valid, o_ready,
    input  in_ready, o0, o1, o2, o3, o_valid, busy, drop_cnt
  );

  modport slave (
    input  s, i, in_valid, o_ready,
    output in_ready, o0, o1, o2, o3, o_valid, busy, drop_cnt
  );
endinterface

// File: rtl/demux1t4_5_buf.sv
// Routes each accepted input word into one of four 2-entry FIFOs selected by s;
// counts stall cycles (valid input while the selected FIFO is full), saturating at 255.
module demux1t4_5_buf #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  demux1t4_5_buf_if.slave bus
);

  logic [3:0]   full;
  logic [3:0]   valid;
  logic [W-1:0] head [4];
  logic         in_ready;
  logic [7:0]   drop_cnt_reg;

  // Readiness looks only at occupancy before the edge, so a same-edge pop
  // never makes room for a push.
  assign in_ready = ~full[bus.s];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [1:0]   cnt_reg;
      logic [1:0]   cnt_next;
      logic         wp_reg;
      logic         rp_reg;
      logic [W-1:0] mem [DEPTH];
      logic         push;
      logic         pop;

      assign push      = bus.in_valid & in_ready & (bus.s == 2'(gi));
      assign pop       = valid[gi] & bus.o_ready[gi];
      assign valid[gi] = (cnt_reg != 2'd0);
      assign full[gi]  = (cnt_reg == 2'(DEPTH));

      always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
          cnt_next = cnt_reg + 2'd1;
        end else if (pop && !push) begin
          cnt_next = cnt_reg - 2'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= 2'd0;
          wp_reg  <= 1'b0;
          rp_reg  <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          if (push) wp_reg <= ~wp_reg;
          if (pop)  rp_reg <= ~rp_reg;
        end
      end

      // Storage needs no reset: the head is masked to zero whenever empty.
      always_ff @(posedge clk) begin
        if (push) mem[wp_reg] <= bus.i;
      end

      assign head[gi] = valid[gi] ? mem[rp_reg] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else if (bus.in_valid && !in_ready && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.o0       = head[0];
  assign bus.o1       = head[1];
  assign bus.o2       = head[2];
  assign bus.o3       = head[3];
  assign bus.o_valid  = valid;
  assign bus.busy     = |valid;
  assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_demux1t4_5_buf.sv
// Scoreboard bench for demux1t4_5_buf: per-channel expected-word queues are
// filled as stimulus is accepted and consumed as the consumer takes words.
module tb_demux1t4_5_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_drop = 0;
  logic [4:0] sq [4][$];

  demux1t4_5_buf_if #(.W(5)) bus ();

  demux1t4_5_buf #(.W(5), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] get_o(int k);
    case (k)
      0:       return bus.o0;
      1:       return bus.o1;
      2:       return bus.o2;
      default: return bus.o3;
    endcase
  endfunction

  // Advance one edge and update the reference model with what the edge does.
  task automatic tick();
    bit         pushed;
    bit [3:0]   popm;
    logic [1:0] ss;
    logic [4:0] ii;
    ss = bus.s;
    ii = bus.i;
    pushed = bus.in_valid && (sq[ss].size() < 2);
    for (int k = 0; k < 4; k++) popm[k] = bus.o_ready[k] && (sq[k].size() > 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (popm[k]) void'(sq[k].pop_front());
    if (pushed) sq[ss].push_back(ii);
    else if (bus.in_valid && exp_drop < 255) exp_drop++;
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.o_ready  = 4'b0;
    bus.s        = 2'd0;
    bus.i        = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (bus.o_valid !== 4'b0 || bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: o_valid=%b busy=%b drop=%0d, need 0/0/0", bus.o_valid, bus.busy, bus.drop_cnt);
    end
    n_cmp++;
    if ({bus.o0, bus.o1, bus.o2, bus.o3} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_data: o0..o3=%h, need 0", {bus.o0, bus.o1, bus.o2, bus.o3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      bus.s = 2'(k);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready s=%0d: got %b need 1", k, bus.in_ready);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_pop_empty();
    bus.o_ready = 4'hF;
    tick();
    tick();
    bus.o_ready = 4'h0;
    n_cmp++;
    if (bus.o_valid !== 4'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pop_empty: o_valid=%b busy=%b need 0000/0", bus.o_valid, bus.busy);
    end
    $display("test_pop_empty done");
  endtask

  task automatic test_single();
    bus.s = 2'd2; bus.i = 5'h15; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.o_valid !== 4'b0100 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_valid: o_valid=%b busy=%b need 0100/1", bus.o_valid, bus.busy);
    end
    n_cmp++;
    if (bus.o2 !== sq[2][0] || bus.o2 !== 5'h15) begin
      n_bad++;
      $display("FAIL single_data: o2=%h need 15", bus.o2);
    end
    n_cmp++;
    if (bus.o0 !== 5'd0 || bus.o1 !== 5'd0 || bus.o3 !== 5'd0) begin
      n_bad++;
      $display("FAIL single_others: o0=%h o1=%h o3=%h need 0", bus.o0, bus.o1, bus.o3);
    end
    bus.o_ready = 4'b0100;
    tick();
    bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.o_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL single_drain: o_valid=%b need 0000", bus.o_valid);
    end
    $display("test_single done");
  endtask

  task automatic test_fill_stall();
    logic [4:0] want [2];
    want[0] = 5'h01;
    want[1] = 5'h02;
    bus.s = 2'd1; bus.in_valid = 1'b1;
    bus.i = 5'h01; tick();
    bus.i = 5'h02; tick();
    bus.i = 5'h03;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_in_ready: got %b need 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.drop_cnt !== 8'(exp_drop) || exp_drop != 1) begin
      n_bad++;
      $display("FAIL stall_drop: got %0d need 1", bus.drop_cnt);
    end
    for (int n = 0; n < 2; n++) begin
      n_cmp++;
      if (bus.o_valid[1] !== 1'b1 || bus.o1 !== want[n]) begin
        n_bad++;
        $display("FAIL stall_pop%0d: o1=%h v=%b need %h", n, bus.o1, bus.o_valid[1], want[n]);
      end
      bus.o_ready = 4'b0010;
      tick();
    end
    bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.o_valid[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_empty: o_valid[1]=%b need 0", bus.o_valid[1]);
    end
    $display("test_fill_stall done");
  endtask

  task automatic test_push_pop_same();
    bus.s = 2'd3; bus.i = 5'h0A; bus.in_valid = 1'b1;
    tick();
    bus.i = 5'h0B; bus.o_ready = 4'b1000;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL pp_in_ready: got %b need 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0; bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.o_valid[3] !== 1'b1 || bus.o3 !== 5'h0B) begin
      n_bad++;
      $display("FAIL pp_head: o3=%h v=%b need 0b/1", bus.o3, bus.o_valid[3]);
    end
    bus.o_ready = 4'b1000;
    tick();
    bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.o_valid[3] !== 1'b0) begin
      n_bad++;
      $display("FAIL pp_count1: o_valid[3]=%b after one pop need 0", bus.o_valid[3]);
    end
    $display("test_push_pop_same done");
  endtask

  task automatic test_full_pop();
    int d0;
    bus.s = 2'd0; bus.in_valid = 1'b1;
    bus.i = 5'h07; tick();
    bus.i = 5'h08; tick();
    d0 = exp_drop;
    bus.i = 5'h11; bus.o_ready = 4'b0001;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fullpop_in_ready: got %b need 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0; bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.drop_cnt !== 8'(d0 + 1)) begin
      n_bad++;
      $display("FAIL fullpop_drop: got %0d need %0d", bus.drop_cnt, d0 + 1);
    end
    n_cmp++;
    if (bus.o0 !== 5'h08 || bus.o0 !== sq[0][0] || sq[0].size() != 1) begin
      n_bad++;
      $display("FAIL fullpop_head: o0=%h need 08", bus.o0);
    end
    bus.o_ready = 4'b0001;
    tick();
    bus.o_ready = 4'b0;
    n_cmp++;
    if (bus.o_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL fullpop_count: o_valid[0]=%b need 0", bus.o_valid[0]);
    end
    $display("test_full_pop done");
  endtask

  task automatic test_saturate();
    bus.s = 2'd2; bus.i = 5'h1C; bus.in_valid = 1'b1;
    for (int n = 0; n < 302; n++) tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.drop_cnt !== 8'd255 || exp_drop != 255) begin
      n_bad++;
      $display("FAIL saturate: drop=%0d need 255", bus.drop_cnt);
    end
    $display("test_saturate done");
  endtask

  task automatic test_back_to_back();
    logic [4:0] ev;
    for (int n = 0; n < 200; n++) begin
      bus.s        = 2'($urandom_range(0, 3));
      bus.i        = 5'($urandom);
      bus.in_valid = 1'($urandom);
      bus.o_ready  = 4'($urandom);
      #1;
      n_cmp++;
      if (bus.in_ready !== (sq[bus.s].size() < 2)) begin
        n_bad++;
        $display("FAIL b2b_in_ready cyc=%0d s=%0d: got %b", n, bus.s, bus.in_ready);
      end
      for (int k = 0; k < 4; k++) begin
        ev = (sq[k].size() > 0) ? sq[k][0] : 5'd0;
        n_cmp++;
        if (bus.o_valid[k] !== (sq[k].size() > 0) || get_o(k) !== ev) begin
          n_bad++;
          $display("FAIL b2b_ch%0d cyc=%0d: o=%h v=%b need %h/%0d", k, n, get_o(k), bus.o_valid[k], ev, sq[k].size());
        end
      end
      n_cmp++;
      if (bus.drop_cnt !== 8'(exp_drop)) begin
        n_bad++;
        $display("FAIL b2b_drop cyc=%0d: got %0d need %0d", n, bus.drop_cnt, exp_drop);
      end
      tick();
    end
    idle();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    idle();
    bus.o_ready = 4'hF;
    tick();
    bus.o_ready = 4'h0;
    bus.s = 2'd1; bus.in_valid = 1'b1;
    bus.i = 5'h05; tick();
    bus.i = 5'h06; tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) sq[k].delete();
    exp_drop = 0;
    n_cmp++;
    if (bus.o_valid !== 4'b0 || bus.drop_cnt !== 8'd0 || bus.o1 !== 5'd0) begin
      n_bad++;
      $display("FAIL midreset: o_valid=%b drop=%0d o1=%h need 0", bus.o_valid, bus.drop_cnt, bus.o1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      bus.s = 2'(k);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL midreset_in_ready s=%0d: got %b need 1", k, bus.in_ready);
      end
    end
    bus.s = 2'd1; bus.i = 5'h1E; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.o_valid !== 4'b0010 || bus.o1 !== 5'h1E) begin
      n_bad++;
      $display("FAIL midreset_resume: o_valid=%b o1=%h need 0010/1e", bus.o_valid, bus.o1);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_single();
    test_fill_stall();
    test_push_pop_same();
    test_full_pop();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1t4_5_buf.md
DEMUX1T4_5_BUF -- requirements
Module: demux1t4_5_buf

Interface
REQ-001 Parameter W, default 5, data width of each channel in bits.
REQ-002 Parameter DEPTH, default 2, number of entries in each per-channel FIFO; only 2 is supported.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s  input  2  destination channel select for the current input word (0..3).
REQ-006 i  input  W  input data word.
REQ-007 in_valid  input  1  asserted when i and s carry a word to deliver.
REQ-008 in_ready  output  1  block can accept a word for channel s this cycle.
REQ-009 o0, o1, o2, o3  output  W each  head-of-FIFO data for channels 0..3.
REQ-010 o_valid  output  4  bit k set when channel k FIFO is non-empty.
REQ-011 o_ready  input  4  bit k set when the channel-k consumer takes its head word.
REQ-012 busy  output  1  OR of all o_valid bits.
REQ-013 drop_cnt  output  8  count of cycles with in_valid=1 and in_ready=0 (stall cycles).

Function
REQ-014 The block SHALL route each accepted word to exactly one of four independent FIFOs; the FIFO is selected by s.
REQ-015 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal NOT full[s], using FIFO occupancy registered before the edge; a pop on the same edge does not free space for a same-cycle push.
REQ-017 in_ready SHALL be combinational in s only; it SHALL NOT depend on in_valid.
REQ-018 Channel-k output transfer SHALL occur when o_valid[k]=1 and o_ready[k]=1; the head entry is removed at that edge.
REQ-019 ok SHALL present the oldest unread word of FIFO k whenever o_valid[k]=1; ok SHALL hold 0 when o_valid[k]=0.
REQ-020 Latency: a word pushed into an empty FIFO SHALL appear on ok with o_valid[k]=1 in the cycle after the accepting edge; there is no same-cycle bypass.
REQ-021 Each FIFO SHALL use a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2); both pointers wrap from 1 to 0.
REQ-022 Simultaneous push and pop on the same channel with count=1 SHALL leave count=1 and preserve order.
REQ-023 Push to channel j and pop from channel k (j != k) on the same edge SHALL be independent.
REQ-024 o_ready[k] asserted while o_valid[k]=0 SHALL have no effect; the count never underflows.
REQ-025 in_valid=1 with full[s] SHALL NOT write; the FIFO is unchanged and drop_cnt increments by 1.
REQ-026 drop_cnt SHALL saturate at 255.
REQ-027 Changing s while in_valid=1 and in_ready=0 is permitted; in_ready re-evaluates for the new s in the same cycle.
REQ-028 Data ordering within each channel SHALL be strictly FIFO; there is no ordering relation across channels.

Reset
REQ-029 rst_n=0 SHALL, asynchronously, clear all counts and pointers and drive o_valid=0, o0..o3=0, busy=0 and drop_cnt=0.
REQ-030 After reset, in_ready SHALL be 1 for every s.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words; no partial word survives.
REQ-032 Normal operation SHALL resume on the first rising edge after rst_n is released.

Verification
REQ-033 Reset, then s=2, i=5'h15, in_valid=1 for one cycle -> next cycle o_valid=4'b0100, o2=5'h15, busy=1; o0, o1, o3=0.
REQ-034 o_ready=0, push 5'h01, 5'h02, 5'h03 to channel 1 on consecutive cycles -> in_ready=0 on the third cycle, drop_cnt=1, and a subsequent pop sequence yields 5'h01 then 5'h02.
REQ-035 Channel 3 holds one word 5'h0A; push 5'h0B with o_ready[3]=1 on the same edge -> o3=5'h0B, o_valid[3]=1, count remains 1.
REQ-036 Push 5'h11 to ch0 while popping ch0 at full (count=2) -> push rejected, drop_cnt increments, ch0 count becomes 1.
REQ-037 Hold in_valid=1 to a full channel for 300 cycles -> drop_cnt=255.
REQ-038 Fill ch1 with 2 words and assert rst_n=0 between edges -> o_valid=0, drop_cnt=0 immediately, in_ready=1 after release.
